// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// One-bit full-adder cell used as the serial bit slice.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic ca
);

    assign s  = a ^ b ^ c;
    assign ca = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial word adder: one operand bit pair per cycle through a single
// full-adder cell, with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, acc, acc_nxt, s_msb;
    logic             creg, s, ca;
    logic [CNT_W-1:0] cnt;
    logic             accept, last;

    fulladder u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .c  (creg),
        .s  (s),
        .ca (ca)
    );

    assign accept = (state == IDLE || state == DONE) && start;
    assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    always_comb begin
        s_msb            = '0;
        s_msb[WIDTH-1]   = s;
        acc_nxt          = (acc >> 1) | s_msb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa  <= '0;
            opb  <= '0;
            acc  <= '0;
            creg <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            opa  <= a;
            opb  <= b;
            creg <= cin;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            opa  <= opa >> 1;
            opb  <= opb >> 1;
            acc  <= acc_nxt;
            creg <= ca;
            cnt  <= cnt + CNT_W'(1);
            // Result ports only update on completion, never with partial sums.
            if (last) begin
                sum  <= acc_nxt;
                cout <= ca;
            end
        end
    end

endmodule
